demux1to2_stream: RTL and testbench
===================================

# demux1to2_stream

Registered 1-to-2 stream demultiplexer: the distribution-side counterpart of the team's 2:1 multiplexers. A single valid/ready input stream is steered by a per-word select to one of two output streams. Each output has its own one-entry holding register, so a stalled output never blocks traffic to the other. It sits between a shared producer and two independent consumers.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- COUNT_W, 8, width of per-output delivery counters (used only with DEMUX2_CNT_EN)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 -> out0, 1 -> out1; sampled only when in_valid=1
- in_valid  input  1  input word present
- in_ready  output  1  demux accepts the word this cycle
- out0_data  output  WIDTH  port-0 word (slot 0 register)
- out0_valid  output  1  slot 0 full
- out0_ready  input  1  port-0 consumer accepts
- out1_data  output  WIDTH  port-1 word (slot 1 register)
- out1_valid  output  1  slot 1 full
- out1_ready  input  1  port-1 consumer accepts
- cnt0  output  COUNT_W  port-0 delivered-word count (DEMUX2_CNT_EN only)
- cnt1  output  COUNT_W  port-1 delivered-word count (DEMUX2_CNT_EN only)

## Operation
- Slot k state: valid_k, data_k. outk_valid = valid_k, outk_data = data_k, both straight from registers.
- s = in_sel. in_ready = !valid_s || outs_ready (combinational; depends on in_sel and selected outs_ready only).
- Accept: in_valid && in_ready -> data_s <= in_data, valid_s <= 1.
- Drain: valid_k && outk_ready -> output handshake on port k; valid_k <= 0 unless slot k is reloaded in the same cycle.
- Simultaneous drain and accept on the same slot: slot reloads, valid_s stays 1, no bubble.
- Unselected slot drains independently in the same cycle as an accept to the other slot.
- Slot full and its consumer stalled: in_ready=0 for words selecting it; word must be held by producer (in_data, in_sel stable until accepted). Words selecting the other slot proceed.
- Word order preserved per output port; no reordering across a port.
- in_valid=0: in_sel and in_data ignored; no state change except drains.
- data_k holds its last value after drain (not cleared).

## Timing
- Reset (rst=1 at clock edge): valid0=valid1=0, data0=data1=0, cnt0=cnt1=0. Hence out0_valid=out1_valid=0, out0_data=out1_data=0; in_ready=1 the first cycle after reset. Reset mid-transfer discards slot contents.
- Latency: word accepted at edge N appears on outs_* in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle sustained to either port, or alternating, when consumers hold ready=1.
- Output valid never drops without a handshake; data stable while valid && !ready.

## Configuration
- DEMUX2_CNT_EN defined: cnt0/cnt1 ports exist; cntk increments by 1 on each port-k output handshake; wraps 2^COUNT_W-1 -> 0; reset to 0.
- DEMUX2_CNT_EN undefined: cnt0/cnt1 ports and counter logic absent; datapath behaviour identical.

## Structure
- Shared package/header: port index constants SEL_PORT0=1'b0, SEL_PORT1=1'b1; default WIDTH.
- Sub-module demux_slot: one-entry register (load, data_in, ready_in, valid, data_out, optional counter), instantiated twice; top holds select decode and in_ready.

## Test plan
- Reset then idle: rst for 2 cycles -> out0_valid=out1_valid=0, data=0, in_ready=1, cnt0=cnt1=0.
- Stream 0x11,0x22,0x33 with in_sel=0,1,0, both readys=1 -> out0 gets 0x11 then 0x33, out1 gets 0x22, each 1 cycle after accept, in_ready stays 1.
- out1_ready=0, send 0xA5 sel=1 then 0x5A sel=1 -> first accepted, in_ready=0 for second; send 0x3C sel=0 meanwhile -> accepted, out0_data=0x3C next cycle; raise out1_ready -> 0xA5 delivered, 0x5A accepted same cycle, appears next cycle.
- Back-to-back 16 words to port 0 with out0_ready=1 -> no bubbles, 16 consecutive out0 handshakes, order preserved.
- Assert rst while both slots full -> next cycle both valids 0, counters 0.
- DEMUX2_CNT_EN, COUNT_W=4: 17 handshakes on port 1 -> cnt1=1 (wrap from 15 to 0 observed), cnt0 unchanged.

Source files
------------

// File: rtl/demux1to2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
// Optional per-port delivery counters are enabled with DEMUX2_CNT_EN.
package demux1to2_stream_pkg;

  localparam logic SEL_PORT0     = 1'b0;
  localparam logic SEL_PORT1     = 1'b1;
  localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register for one demux port.
// Optional delivered-word counter is enabled with DEMUX2_CNT_EN.
module demux_slot
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX2_CNT_EN
  , parameter int COUNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
`ifdef DEMUX2_CNT_EN
  ,
  output logic [COUNT_W-1:0] cnt
`endif
);

  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             drain;

  assign drain = valid_reg && ready_in;

  // A load in the same cycle as a drain wins, so the slot refills without a bubble.
  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (drain) valid_next = 1'b0;
    if (load) begin
      valid_next = 1'b1;
      data_next  = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign valid    = valid_reg;
  assign data_out = data_reg;

`ifdef DEMUX2_CNT_EN
  logic [COUNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (drain) cnt_next = cnt_reg + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;
`endif

endmodule

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready demultiplexer with independent per-port slots.
// Define DEMUX2_CNT_EN to add the cnt0/cnt1 delivery counters.
module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX2_CNT_EN
  , parameter int COUNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
`endif
);

  logic [1:0]       slot_load;
  logic [1:0]       slot_ready;
  logic [1:0]       slot_valid;
  logic [WIDTH-1:0] slot_data [2];
`ifdef DEMUX2_CNT_EN
  logic [COUNT_W-1:0] slot_cnt [2];
`endif

  assign slot_ready = {out1_ready, out0_ready};

  // Only the selected slot gates acceptance; the other slot never stalls the input.
  always_comb begin
    in_ready = 1'b0;
    if (in_sel == SEL_PORT1) in_ready = !slot_valid[1] || out1_ready;
    else                     in_ready = !slot_valid[0] || out0_ready;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      localparam logic SEL_THIS = (gi == 0) ? SEL_PORT0 : SEL_PORT1;

      assign slot_load[gi] = in_valid && in_ready && (in_sel == SEL_THIS);

      demux_slot #(
        .WIDTH   (WIDTH)
`ifdef DEMUX2_CNT_EN
        , .COUNT_W (COUNT_W)
`endif
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (slot_load[gi]),
        .data_in  (in_data),
        .ready_in (slot_ready[gi]),
        .valid    (slot_valid[gi]),
        .data_out (slot_data[gi])
`ifdef DEMUX2_CNT_EN
        , .cnt    (slot_cnt[gi])
`endif
      );
    end
  endgenerate

  assign out0_valid = slot_valid[0];
  assign out0_data  = slot_data[0];
  assign out1_valid = slot_valid[1];
  assign out1_data  = slot_data[1];
`ifdef DEMUX2_CNT_EN
  assign cnt0 = slot_cnt[0];
  assign cnt1 = slot_cnt[1];
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed self-checking bench for demux1to2_stream.
// Counter checks run only when DEMUX2_CNT_EN is defined (COUNT_W=4).
module tb_demux1to2_stream;

  localparam int WIDTH = 8;
`ifdef DEMUX2_CNT_EN
  localparam int COUNT_W = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
`ifdef DEMUX2_CNT_EN
  logic [COUNT_W-1:0] cnt0;
  logic [COUNT_W-1:0] cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1to2_stream #(
    .WIDTH   (WIDTH)
`ifdef DEMUX2_CNT_EN
    , .COUNT_W (COUNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX2_CNT_EN
    , .cnt0     (cnt0)
    , .cnt1     (cnt1)
`endif
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b exp 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
    checks++; if (out0_data !== 8'h00) begin errors++; $display("FAIL reset_out0_data got %h exp 00", out0_data); end
    checks++; if (out1_data !== 8'h00) begin errors++; $display("FAIL reset_out1_data got %h exp 00", out1_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel0 got %b exp 1", in_ready); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel1 got %b exp 1", in_ready); end
`ifdef DEMUX2_CNT_EN
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_stream();
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_11 got %b exp 1", in_ready); end
    cyc();
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL stream_out0_11 got %b/%h exp 1/11", out0_valid, out0_data); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stream_out1_idle got %b exp 0", out1_valid); end
    drive(1'b1, 1'b1, 8'h22);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_22 got %b exp 1", in_ready); end
    cyc();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL stream_out1_22 got %b/%h exp 1/22", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL stream_out0_drained got %b exp 0", out0_valid); end
    drive(1'b1, 1'b0, 8'h33);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_33 got %b exp 1", in_ready); end
    cyc();
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL stream_out0_33 got %b/%h exp 1/33", out0_valid, out0_data); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stream_out1_drained got %b exp 0", out1_valid); end
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    checks++; if ({out0_valid, out0_data} !== {1'b0, 8'h33}) begin errors++; $display("FAIL stream_idle_hold got %b/%h exp 0/33", out0_valid, out0_data); end
    $display("test_stream done: 11->p0 22->p1 33->p0");
  endtask

  task automatic test_stall();
    out0_ready = 1'b1; out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'hA5);
    cyc();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL stall_out1_a5 got %b/%h exp 1/a5", out1_valid, out1_data); end
    drive(1'b1, 1'b1, 8'h5A);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_5a got %b exp 0", in_ready); end
    cyc();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL stall_out1_hold got %b/%h exp 1/a5", out1_valid, out1_data); end
    drive(1'b1, 1'b0, 8'h3C);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_3c got %b exp 1", in_ready); end
    cyc();
    checks++; if ({out0_valid, out0_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL stall_out0_3c got %b/%h exp 1/3c", out0_valid, out0_data); end
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL stall_out1_still got %b/%h exp 1/a5", out1_valid, out1_data); end
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h5A);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    cyc();
    checks++; if ({out1_valid, out1_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL stall_out1_5a got %b/%h exp 1/5a", out1_valid, out1_data); end
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL stall_out0_drained got %b exp 0", out0_valid); end
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stall_out1_drained got %b exp 0", out1_valid); end
    $display("test_stall done: a5 held, 3c passed, 5a reloaded");
  endtask

  task automatic test_back_to_back();
    int hs;
    logic [WIDTH-1:0] exp_d;
    hs = 0;
    out0_ready = 1'b1; out1_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_d = 8'h40 + 8'(i);
      drive(1'b1, 1'b0, exp_d);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      cyc();
      checks++; if ({out0_valid, out0_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL b2b_out0[%0d] got %b/%h exp 1/%h", i, out0_valid, out0_data, exp_d); end
      else hs++;
    end
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %b exp 0", out0_valid); end
    checks++; if (hs !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", hs); end
    $display("test_back_to_back done: %0d words on port 0", hs);
  endtask

  task automatic test_reset_midflow();
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    cyc();
    drive(1'b1, 1'b1, 8'h88);
    cyc();
    drive(1'b0, 1'b0, 8'h00);
    checks++; if ({out0_valid, out1_valid} !== 2'b11) begin errors++; $display("FAIL midrst_full got %b exp 11", {out0_valid, out1_valid}); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL midrst_valids got %b exp 00", {out0_valid, out1_valid}); end
    checks++; if ({out0_data, out1_data} !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h exp 0000", {out0_data, out1_data}); end
`ifdef DEMUX2_CNT_EN
    checks++; if ({cnt0, cnt1} !== 8'h00) begin errors++; $display("FAIL midrst_cnt got %h exp 00", {cnt0, cnt1}); end
`endif
    $display("test_reset_midflow done");
  endtask

`ifdef DEMUX2_CNT_EN
  task automatic test_counter_wrap();
    out0_ready = 1'b0; out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      cyc();
      // After accepting word i, i handshakes have completed on port 1.
      if (i == 15) begin
        checks++; if (cnt1 !== 4'd15) begin errors++; $display("FAIL cnt1_at15 got %0d exp 15", cnt1); end
      end
    end
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL cnt1_wrap got %0d exp 0", cnt1); end
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL cnt1_final got %0d exp 1", cnt1); end
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL cnt0_unchanged got %0d exp 0", cnt0); end
    $display("test_counter_wrap done: cnt1=%0d", cnt1);
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_reset_midflow();
`ifdef DEMUX2_CNT_EN
    test_counter_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
